// File: rtl/glb_bank_sram_array.sv
// Global-buffer bank memory: NUM_MACROS SRAM macros selected by the upper
// word-address bits, with a fully pipelined read path of READ_LATENCY cycles,
// a read-valid strobe and a registered read/write collision pulse.

// Behavioural model of one SRAM macro. All strobes are active-low. A write
// takes effect at the clock edge. A read presents Q one cycle after the
// request, and Q holds its value while the macro is idle.
module glb_bank_sram_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  ceb,
    input  logic                  web,
    input  logic [DATA_WIDTH-1:0] bweb,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] q_r;

    // Masked write or read access when the macro is enabled; contents are never reset.
    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web) begin
                mem_r[a] <= (mem_r[a] & bweb) | (d & ~bweb);
            end else begin
                q_r <= mem_r[a];
            end
        end
    end

    assign q = q_r;

endmodule

module glb_bank_sram_array #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 17,
    parameter int BYTE_OFFSET  = 3,
    parameter int NUM_MACROS   = 4,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_in_bit_sel,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  collision
);

    localparam int WA   = ADDR_WIDTH - BYTE_OFFSET;
    localparam int MS   = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 0;
    localparam int MS_W = (MS > 0) ? MS : 1;
    localparam int MA   = WA - MS;

    // Byte-offset bits below BYTE_OFFSET are intentionally not decoded.
    logic [WA-1:0]         word_addr_s;
    logic [MA-1:0]         macro_addr_s;
    logic [MS_W-1:0]       macro_idx_s;
    logic [NUM_MACROS-1:0] ceb_s;
    logic                  web_s;
    logic [DATA_WIDTH-1:0] bweb_s;
    logic [DATA_WIDTH-1:0] q_s [NUM_MACROS];
    logic [DATA_WIDTH-1:0] q_mux_s;

    logic                  rd_v0_r;
    logic [MS_W-1:0]       rd_idx0_r;
    logic                  collision_r;

    assign word_addr_s  = addr[ADDR_WIDTH-1:BYTE_OFFSET];
    assign macro_addr_s = word_addr_s[MA-1:0];

    generate
        if (MS > 0) begin : g_idx
            assign macro_idx_s = word_addr_s[WA-1:MA];
        end else begin : g_idx_single
            assign macro_idx_s = 1'b0;
        end
    endgenerate

    assign web_s  = ~wen;
    assign bweb_s = ~data_in_bit_sel;

    // Enable only the addressed macro; everything is disabled while reset is high.
    always_comb begin
        ceb_s = {NUM_MACROS{1'b1}};
        for (int i = 0; i < NUM_MACROS; i++) begin
            if (!reset && (ren || wen) && (macro_idx_s == i[MS_W-1:0])) begin
                ceb_s[i] = 1'b0;
            end else begin
                ceb_s[i] = 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_MACROS; g++) begin : g_macro
            glb_bank_sram_gen #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (MA)
            ) u_macro (
                .clk  (clk),
                .ceb  (ceb_s[g]),
                .web  (web_s),
                .bweb (bweb_s),
                .d    (data_in),
                .a    (macro_addr_s),
                .q    (q_s[g])
            );
        end
    endgenerate

    // AND-OR select of the macro output indexed by the request registered one cycle earlier.
    always_comb begin
        q_mux_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_MACROS; i++) begin
            q_mux_s = q_mux_s | (q_s[i] & {DATA_WIDTH{rd_idx0_r == i[MS_W-1:0]}});
        end
    end

    // First read stage (valid + macro index) and the collision pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v0_r     <= 1'b0;
            rd_idx0_r   <= {MS_W{1'b0}};
            collision_r <= 1'b0;
        end else begin
            rd_v0_r     <= ren & ~wen;
            rd_idx0_r   <= macro_idx_s;
            collision_r <= ren & wen;
        end
    end

    // Data stages 1..READ_LATENCY-1. Stage 1 samples the macro Q exactly one
    // cycle after the request, so later accesses cannot disturb an in-flight
    // read. The last stage only loads on a valid result so data_out holds.
    generate
        for (genvar j = 1; j < READ_LATENCY; j++) begin : g_stage
            localparam bit IS_LAST = (j == READ_LATENCY - 1);
            logic                  in_v_s;
            logic [DATA_WIDTH-1:0] in_d_s;
            logic                  vld_r;
            logic [DATA_WIDTH-1:0] dat_r;

            if (j == 1) begin : g_first
                assign in_v_s = rd_v0_r;
                assign in_d_s = q_mux_s;
            end else begin : g_rest
                assign in_v_s = g_stage[j-1].vld_r;
                assign in_d_s = g_stage[j-1].dat_r;
            end

            // Shift valid and data together down the read pipeline.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_r <= 1'b0;
                    dat_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    vld_r <= in_v_s;
                    if (!IS_LAST || in_v_s) begin
                        dat_r <= in_d_s;
                    end
                end
            end
        end
    endgenerate

    assign rd_valid  = g_stage[READ_LATENCY-1].vld_r;
    assign data_out  = g_stage[READ_LATENCY-1].dat_r;
    assign collision = collision_r;

endmodule
